// File: rtl/min_scan_ctrl.sv
// Frame minimum scanner: collects FRAME_LEN 4-bit samples and reports the smallest value,
// how often it occurred, and a seven-segment code for it.
//
// state   | meaning
// IDLE    | waiting for start; last result (if any) held
// COLLECT | accepting samples, tracking working min/count
// DONE    | one-cycle commit pulse, then back to IDLE
module min_scan_ctrl #(
    parameter int FRAME_LEN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic       busy,
    output logic       done,
    output logic       result_valid,
    output logic [3:0] min_value,
    output logic [3:0] min_count,
    output logic       tie,
    output logic [6:0] seg_code
);

    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] idx;
    logic [3:0] work_min;
    logic [3:0] work_cnt;
    logic [3:0] next_min;
    logic [3:0] next_cnt;

    // Working min/count including the sample on in_data, so the last sample can be
    // committed straight into the result registers on the same edge.
    always_comb begin
        next_min = work_min;
        next_cnt = work_cnt;
        if (idx == 4'd0) begin
            next_min = in_data;
            next_cnt = 4'd1;
        end else if (in_data < work_min) begin
            next_min = in_data;
            next_cnt = 4'd1;
        end else if (in_data == work_min) begin
            next_cnt = work_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            work_min     <= '0;
            work_cnt     <= '0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            min_value    <= '0;
            min_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state        <= COLLECT;
                        idx          <= '0;
                        work_min     <= '0;
                        work_cnt     <= '0;
                        in_ready     <= 1'b1;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (abort) begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end else if (in_valid) begin
                        work_min <= next_min;
                        work_cnt <= next_cnt;
                        if (idx == LAST_IDX) begin
                            state        <= DONE;
                            in_ready     <= 1'b0;
                            done         <= 1'b1;
                            result_valid <= 1'b1;
                            min_value    <= next_min;
                            min_count    <= next_cnt;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    assign tie = (min_count > 4'd1);

    always_comb begin
        seg_code = 7'h00;
        if (result_valid) begin
            case (min_value)
                4'h0: seg_code = 7'h77;
                4'h1: seg_code = 7'h24;
                4'h2: seg_code = 7'h5d;
                4'h3: seg_code = 7'h6d;
                4'h4: seg_code = 7'h2e;
                4'h5: seg_code = 7'h6b;
                4'h6: seg_code = 7'h7b;
                4'h7: seg_code = 7'h25;
                4'h8: seg_code = 7'h7f;
                4'h9: seg_code = 7'h6f;
                4'hA: seg_code = 7'h3f;
                4'hB: seg_code = 7'h7a;
                4'hC: seg_code = 7'h53;
                4'hD: seg_code = 7'h7c;
                4'hE: seg_code = 7'h5b;
                4'hF: seg_code = 7'h1b;
                default: seg_code = 7'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_min_scan_ctrl.sv
// Directed bench for min_scan_ctrl: per-cycle vector table for whole frames, plus
// hand sequences for gapped input, abort, mid-frame reset and held start.
module tb_min_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       in_ready, busy, done, result_valid, tie;
    logic [3:0] min_value, min_count;
    logic [6:0] seg_code;

    min_scan_ctrl #(.FRAME_LEN(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .busy(busy), .done(done), .result_valid(result_valid),
        .min_value(min_value), .min_count(min_count), .tie(tie),
        .seg_code(seg_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rdy;
        logic       bsy;
        logic       dn;
        logic       rv;
        logic [3:0] mv;
        logic [3:0] mc;
        logic       t;
        logic [6:0] seg;
    } outs_t;

    typedef struct {
        logic       st;
        logic       ab;
        logic       vl;
        logic [3:0] d;
        outs_t      exp;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   failed = 0;

    function automatic outs_t mk(input logic rdy, input logic bsy, input logic dn,
                                 input logic rv, input logic [3:0] mv,
                                 input logic [3:0] mc, input logic [6:0] seg);
        outs_t o;
        o.rdy = rdy; o.bsy = bsy; o.dn = dn; o.rv = rv;
        o.mv = mv; o.mc = mc; o.t = (mc > 4'd1); o.seg = seg;
        return o;
    endfunction

    function automatic outs_t actual();
        outs_t o;
        o.rdy = in_ready; o.bsy = busy; o.dn = done; o.rv = result_valid;
        o.mv = min_value; o.mc = min_count; o.t = tie; o.seg = seg_code;
        return o;
    endfunction

    task automatic check(input string name, input outs_t exp);
        outs_t act;
        act = actual();
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got rdy=%b busy=%b done=%b rv=%b min=%h cnt=%0d tie=%b seg=%h, want rdy=%b busy=%b done=%b rv=%b min=%h cnt=%0d tie=%b seg=%h",
                     name, act.rdy, act.bsy, act.dn, act.rv, act.mv, act.mc, act.t, act.seg,
                     exp.rdy, exp.bsy, exp.dn, exp.rv, exp.mv, exp.mc, exp.t, exp.seg);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic ab, input logic vl, input logic [3:0] d);
        start = st; abort = ab; in_valid = vl; in_data = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic st, input logic ab, input logic vl, input logic [3:0] d,
                       input outs_t exp);
        vec_t v;
        v.st = st; v.ab = ab; v.vl = vl; v.d = d; v.exp = exp;
        vecs.push_back(v);
    endtask

    // One full back-to-back frame: start cycle, 8 sample cycles, then the DONE->IDLE cycle.
    task automatic add_frame(input logic [31:0] samples, input logic [3:0] pmv,
                             input logic [3:0] pmc, input logic [3:0] mv,
                             input logic [3:0] mc, input logic [6:0] seg);
        add(1'b1, 1'b0, 1'b0, 4'h0, mk(1'b1, 1'b1, 1'b0, 1'b0, pmv, pmc, 7'h00));
        for (int i = 0; i < 7; i++)
            add(1'b0, 1'b0, 1'b1, samples[31-4*i -: 4],
                mk(1'b1, 1'b1, 1'b0, 1'b0, pmv, pmc, 7'h00));
        add(1'b0, 1'b0, 1'b1, samples[3:0], mk(1'b0, 1'b1, 1'b1, 1'b1, mv, mc, seg));
        add(1'b0, 1'b0, 1'b0, 4'h0, mk(1'b0, 1'b0, 1'b0, 1'b1, mv, mc, seg));
    endtask

    logic [3:0] frame_a[8];
    int         accepted;
    int         done_at;
    int         done_pulses;

    initial begin
        frame_a = '{4'h9, 4'h4, 4'h7, 4'h4, 4'hC, 4'hF, 4'h5, 4'h8};

        add_frame(32'h9474CF58, 4'h0, 4'h0, 4'h4, 4'd2, 7'h2e);
        add_frame(32'h33333333, 4'h4, 4'd2, 4'h3, 4'd8, 7'h6d);
        add_frame(32'hFEDCBA90, 4'h3, 4'd8, 4'h0, 4'd1, 7'h77);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 7'h00));
        rst_n = 1'b1;
        step();
        check("idle_after_reset", mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 7'h00));

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].ab, vecs[i].vl, vecs[i].d);
            step();
            check($sformatf("vec%0d", i), vecs[i].exp);
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0);

        // in_valid in IDLE must not disturb the held result
        drive(1'b0, 1'b0, 1'b1, 4'h0);
        repeat (2) begin
            step();
            check("idle_valid_ignored", mk(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'd1, 7'h77));
        end

        // gapped input: zeros presented on invalid cycles must never be taken
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        step();
        accepted = 0;
        done_at = -1;
        for (int i = 0; i < 24 && done_at < 0; i++) begin
            if (i % 2 == 0) drive(1'b0, 1'b0, 1'b1, frame_a[accepted]);
            else            drive(1'b0, 1'b0, 1'b0, 4'h0);
            if (i % 2 == 0) accepted++;
            step();
            if (done) done_at = i;
        end
        tests++;
        if (done_at != 14) begin
            failed++;
            $display("FAIL gapped_done_cycle: got %0d want 14", done_at);
        end
        check("gapped_result", mk(1'b0, 1'b1, 1'b1, 1'b1, 4'h4, 4'd2, 7'h2e));
        drive(1'b0, 1'b0, 1'b1, 4'h0);
        step();
        check("done_valid_ignored", mk(1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 4'd2, 7'h2e));

        // abort after 3 samples with a sample presented
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 4'h1);
            step();
        end
        drive(1'b0, 1'b1, 1'b1, 4'h0);
        step();
        check("abort_to_idle", mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 4'd2, 7'h00));
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        step();
        check("abort_no_done", mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 4'd2, 7'h00));

        // abort outside COLLECT is ignored: a clean frame follows
        drive(1'b0, 1'b1, 1'b0, 4'h0);
        step();
        check("abort_idle_ignored", mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 4'd2, 7'h00));

        // asynchronous reset part-way through a frame
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 4'h2);
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 7'h00));
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        step();
        check("reset_held", mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 7'h00));
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        step();
        check("start_after_reset", mk(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 7'h00));
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b0, 1'b1, 4'h1);
            step();
            check_bit("no_early_done", done, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b1, 4'h1);
        step();
        check("ones_frame", mk(1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 4'd8, 7'h24));
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        step();

        // start held high with continuous data: one frame per IDLE visit
        drive(1'b1, 1'b0, 1'b1, 4'h5);
        done_pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done) done_pulses++;
        end
        tests++;
        if (done_pulses != 3) begin
            failed++;
            $display("FAIL held_start_pulses: got %0d want 3", done_pulses);
        end
        check("held_start_result", mk(1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 4'd8, 7'h6b));
        drive(1'b0, 1'b0, 1'b0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
